// File: rtl/alu_multicycle.sv
// ----------------------------------------------------------------------------
// alu_multicycle
//   Multi-cycle ALU for the CPU datapath. It decodes the opcode and operand
//   type from a 16-bit instruction. ADD, SUB and the logic ops finish in one
//   cycle. Shifts move one bit per cycle, and MUL is a shift-add that handles
//   one multiplier bit per cycle. The control unit uses a start/busy/done
//   handshake.
//
// Ports
//   clk          rising-edge system clock
//   reset        synchronous active-high reset; aborts any operation
//   start        operation request, accepted only while busy is low
//   instruction  [15:12] opcode, [11] type (0 = R, 1 = I), [10:8] Rd (unused)
//   rsdata       operand A
//   rmdata       operand B for R-type
//   N            immediate, operand B for I-type
//   busy         high while an iterative operation is executing
//   done         one-cycle pulse; aluout and the flags are valid
//   aluout       result, held until the next operation completes
//   carry        carry / no-borrow / last shifted-out bit / MUL overflow
//   zero         aluout == 0
//   neg          aluout MSB
// ----------------------------------------------------------------------------
module alu_multicycle #(
   parameter int WIDTH  = 16,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [15:0]      instruction,
   input  logic [WIDTH-1:0] rsdata,
   input  logic [WIDTH-1:0] rmdata,
   input  logic [WIDTH-1:0] N,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] aluout,
   output logic             carry,
   output logic             zero,
   output logic             neg
);

   localparam int KW = $clog2(WIDTH);      // shift-amount width
   localparam int CW = $clog2(WIDTH + 1);  // iteration counter width

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t             state;
   logic [3:0]         op_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   sh_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] acc_q;

   logic [3:0]         opc_in;
   logic [WIDTH-1:0]   b_in;
   logic [KW-1:0]      k_in;
   logic               accept;
   logic               is_mul_in;
   logic               iter_in;
   logic [WIDTH:0]     single_res;

   logic [WIDTH-1:0]   sh_nxt;
   logic               sh_bit;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   fin_res;
   logic               fin_c;

   // Rd is decoded by the register file, not here.
   logic unused_rd;
   assign unused_rd = ^instruction[10:8];

   // Result of the operations that finish in the accept cycle. Shifts reach
   // this function only when k = 0, so they pass A through with carry = 0.
   function automatic logic [WIDTH:0] single_op(input logic [3:0]       opc,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      logic [WIDTH:0] r;
      r = '0;
      case (opc)
         4'h8: r = {1'b0, a} + {1'b0, b};
         4'h9: begin
            r[WIDTH-1:0] = a - b;
            r[WIDTH]     = (a >= b);
         end
         4'hA: r = {1'b0, a & b};
         4'hB: r = {1'b0, a | b};
         4'hC: r = {1'b0, a ^ b};
         4'hD, 4'hE: r = {1'b0, a};
         default: r = '0;
      endcase
      return r;
   endfunction

   assign opc_in     = instruction[15:12];
   assign b_in       = instruction[11] ? N : rmdata;
   assign k_in       = b_in[KW-1:0];
   assign accept     = start && !busy;
   assign is_mul_in  = MUL_EN && (opc_in == 4'hF);
   assign iter_in    = is_mul_in ||
                       (((opc_in == 4'hD) || (opc_in == 4'hE)) && (k_in != '0));
   assign single_res = single_op(opc_in, rsdata, b_in);

   // One iteration step. The final result is taken from the stepped values,
   // so it is written in the same edge that moves the FSM to DONE.
   always_comb begin
      acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
      if (op_q == 4'hD) begin
         sh_nxt = sh_q << 1;
         sh_bit = sh_q[WIDTH-1];
      end else begin
         sh_nxt = sh_q >> 1;
         sh_bit = sh_q[0];
      end
      if (op_q == 4'hF) begin
         fin_res = acc_nxt[WIDTH-1:0];
         fin_c   = |acc_nxt[2*WIDTH-1:WIDTH];
      end else begin
         fin_res = sh_nxt;
         fin_c   = sh_bit;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt_q  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         aluout <= '0;
         carry  <= 1'b0;
         zero   <= 1'b0;
         neg    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            EXEC: begin
               sh_q     <= sh_nxt;
               acc_q    <= acc_nxt;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  aluout <= fin_res;
                  carry  <= fin_c;
                  zero   <= (fin_res == '0);
                  neg    <= fin_res[WIDTH-1];
               end
            end
            default: begin
               // IDLE and DONE both accept a new request (busy is low).
               state <= IDLE;
               if (accept) begin
                  op_q     <= opc_in;
                  sh_q     <= rsdata;
                  mcand_q  <= {{WIDTH{1'b0}}, rsdata};
                  mplier_q <= b_in;
                  acc_q    <= '0;
                  cnt_q    <= is_mul_in ? CW'(WIDTH) : CW'(k_in);
                  if (iter_in) begin
                     state <= EXEC;
                     busy  <= 1'b1;
                  end else begin
                     state  <= DONE;
                     done   <= 1'b1;
                     aluout <= single_res[WIDTH-1:0];
                     carry  <= single_res[WIDTH];
                     zero   <= (single_res[WIDTH-1:0] == '0);
                     neg    <= single_res[WIDTH-1];
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] instruction;
   logic [15:0] rsdata;
   logic [15:0] rmdata;
   logic [15:0] n_imm;
   logic        busy;
   logic        done;
   logic [15:0] aluout;
   logic        carry;
   logic        zero;
   logic        neg;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_multicycle #(.WIDTH(16), .MUL_EN(1'b1)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .instruction (instruction),
      .rsdata      (rsdata),
      .rmdata      (rmdata),
      .N           (n_imm),
      .busy        (busy),
      .done        (done),
      .aluout      (aluout),
      .carry       (carry),
      .zero        (zero),
      .neg         (neg)
   );

   // Reference model: plain unsigned arithmetic on wide integers.
   function automatic void model(input logic [3:0] opc, input logic [15:0] a,
                                 input logic [15:0] b, output logic [15:0] r,
                                 output logic c, output int lat);
      logic [31:0] w;
      int          k;
      k   = int'(b[3:0]);
      r   = 16'h0;
      c   = 1'b0;
      lat = 1;
      case (opc)
         4'h8: begin w = 32'(a) + 32'(b); r = w[15:0]; c = (w >= 32'h10000); end
         4'h9: begin r = a - b; c = (a >= b); end
         4'hA: r = a & b;
         4'hB: r = a | b;
         4'hC: r = a ^ b;
         4'hD: begin
            w = 32'(a) << k; r = w[15:0]; c = (k != 0) && w[16]; lat = 1 + k;
         end
         4'hE: begin
            r = a >> k; c = (k != 0) && a[k-1]; lat = 1 + k;
         end
         4'hF: begin
            w = 32'(a) * 32'(b); r = w[15:0]; c = (w[31:16] != 16'h0); lat = 17;
         end
         default: ;
      endcase
   endfunction

   // Issues one operation and observes it until done. Reports the latency in
   // cycles after the accept edge and whether busy/hold/pulse behaviour held.
   // A stray start is pulsed in cycle 'glitch' (0 = none) while busy.
   task automatic exec_op(input logic [3:0] opc, input logic typ,
                          input logic [15:0] a, input logic [15:0] rm,
                          input logic [15:0] nn, input int glitch,
                          output logic [15:0] r, output logic c,
                          output logic z, output logic ng,
                          output int lat, output bit side_ok);
      logic [15:0] prev;
      @(negedge clk);
      prev        = aluout;
      side_ok     = 1'b1;
      instruction = {opc, typ, 3'($urandom), 8'($urandom)};
      rsdata      = a;
      rmdata      = rm;
      n_imm       = nn;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start       = 1'b0;
      instruction = 16'($urandom);
      rsdata      = 16'($urandom);
      rmdata      = 16'($urandom);
      n_imm       = 16'($urandom);
      lat = 1;
      while (!done && lat < 100) begin
         if (!busy || aluout !== prev) side_ok = 1'b0;
         if (lat == glitch) begin
            start       = 1'b1;
            instruction = 16'($urandom);
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      start = 1'b0;
      if (lat >= 100) lat = -1;
      if (busy) side_ok = 1'b0;
      r  = aluout;
      c  = carry;
      z  = zero;
      ng = neg;
      @(posedge clk);
      #1;
      if (done || aluout !== r) side_ok = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; instruction = 16'h8000;
      rsdata = 16'h0; rmdata = 16'h0; n_imm = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({busy, done, carry, zero, neg, aluout} !== 21'h0) begin
         bad++;
         $display("FAIL reset_state got=%h required=0",
                  {busy, done, carry, zero, neg, aluout});
      end
      reset = 1'b0;
   endtask

   task automatic test_add_sub;
      logic [15:0] r; logic c, z, ng; int lat; bit ok;
      exec_op(4'h8, 1'b0, 16'hFFFF, 16'h0001, 16'h1234, 0, r, c, z, ng, lat, ok);
      total++;
      if ({8'(lat), r, c, z, ng, ok} !== {8'd1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL add_r got=%h required=%h (lat,res,c,z,n,ok)",
                  {8'(lat), r, c, z, ng, ok}, {8'd1, 16'h0000, 4'b1101});
      end
      exec_op(4'h9, 1'b1, 16'd5, 16'd100, 16'd7, 0, r, c, z, ng, lat, ok);
      total++;
      if ({8'(lat), r, c, z, ng, ok} !== {8'd1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL sub_i got=%h required=%h (lat,res,c,z,n,ok)",
                  {8'(lat), r, c, z, ng, ok}, {8'd1, 16'hFFFE, 4'b0011});
      end
   endtask

   task automatic test_mul;
      logic [15:0] r; logic c, z, ng; int lat; bit ok;
      exec_op(4'hF, 1'b0, 16'd300, 16'd300, 16'd0, 5, r, c, z, ng, lat, ok);
      total++;
      if ({8'(lat), r, c, z, ng, ok} !== {8'd17, 16'h5F90, 1'b1, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL mul_300 got=%h required=%h (lat,res,c,z,n,ok)",
                  {8'(lat), r, c, z, ng, ok}, {8'd17, 16'h5F90, 4'b1001});
      end
   endtask

   task automatic test_shift;
      logic [15:0] r; logic c, z, ng; int lat; bit ok;
      exec_op(4'hD, 1'b1, 16'h8001, 16'h0000, 16'd4, 0, r, c, z, ng, lat, ok);
      total++;
      if ({8'(lat), r, c, z, ng, ok} !== {8'd5, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL shl_4 got=%h required=%h (lat,res,c,z,n,ok)",
                  {8'(lat), r, c, z, ng, ok}, {8'd5, 16'h0010, 4'b0001});
      end
      exec_op(4'hD, 1'b0, 16'h8000, 16'h0010, 16'h0, 0, r, c, z, ng, lat, ok);
      total++;
      if ({8'(lat), r, c, z, ng, ok} !== {8'd1, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL shl_k0 got=%h required=%h (lat,res,c,z,n,ok)",
                  {8'(lat), r, c, z, ng, ok}, {8'd1, 16'h8000, 4'b0011});
      end
      exec_op(4'hE, 1'b0, 16'h0003, 16'h0001, 16'h0, 0, r, c, z, ng, lat, ok);
      total++;
      if ({8'(lat), r, c, z, ng, ok} !== {8'd2, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL shr_1 got=%h required=%h (lat,res,c,z,n,ok)",
                  {8'(lat), r, c, z, ng, ok}, {8'd2, 16'h0001, 4'b1001});
      end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      instruction = {4'h8, 1'b0, 11'h0}; rsdata = 16'd2; rmdata = 16'd3; start = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({done, aluout, carry} !== {1'b1, 16'd5, 1'b0}) begin
         bad++;
         $display("FAIL b2b_add got=%h required=%h", {done, aluout, carry}, {1'b1, 16'd5, 1'b0});
      end
      instruction = {4'hC, 1'b0, 11'h0}; rsdata = 16'hF0F0; rmdata = 16'hFFFF;
      @(posedge clk);
      #1;
      start = 1'b0;
      total++;
      if ({done, aluout, carry, zero, neg} !== {1'b1, 16'h0F0F, 3'b000}) begin
         bad++;
         $display("FAIL b2b_xor got=%h required=%h", {done, aluout, carry, zero, neg},
                  {1'b1, 16'h0F0F, 3'b000});
      end
      @(posedge clk);
      #1;
      total++;
      if ({done, aluout} !== {1'b0, 16'h0F0F}) begin
         bad++;
         $display("FAIL b2b_hold got=%h required=%h", {done, aluout}, {1'b0, 16'h0F0F});
      end
   endtask

   task automatic test_mid_reset;
      int dones;
      @(negedge clk);
      instruction = {4'hF, 1'b0, 11'h0}; rsdata = 16'd300; rmdata = 16'd300; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL midrst_busy got=%b required=1", busy);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      total++;
      if ({busy, done, carry, zero, neg, aluout} !== 21'h0) begin
         bad++;
         $display("FAIL midrst_state got=%h required=0",
                  {busy, done, carry, zero, neg, aluout});
      end
      dones = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      total++;
      if (dones != 0) begin
         bad++;
         $display("FAIL midrst_nodone got=%0d required=0", dones);
      end
   endtask

   task automatic test_random;
      logic [15:0] r, a, rm, nn, er; logic c, z, ng, ec, typ; logic [3:0] opc;
      int lat, elat; bit ok;
      for (int i = 0; i < 60; i++) begin
         opc = 4'($urandom_range(0, 15));
         typ = 1'($urandom);
         a   = 16'($urandom);
         rm  = 16'($urandom);
         nn  = 16'($urandom);
         if (i % 4 == 0) a = 16'h0;
         model(opc, a, typ ? nn : rm, er, ec, elat);
         exec_op(opc, typ, a, rm, nn, $urandom_range(0, 12), r, c, z, ng, lat, ok);
         total++;
         if ({8'(lat), r, c, z, ng, ok} !==
             {8'(elat), er, ec, (er == 16'h0), er[15], 1'b1}) begin
            bad++;
            $display("FAIL rand_op%0d opc=%h got=%h required=%h (lat,res,c,z,n,ok)",
                     i, opc, {8'(lat), r, c, z, ng, ok},
                     {8'(elat), er, ec, (er == 16'h0), er[15], 1'b1});
         end
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_mul();
      test_shift();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
